// File: rtl/soc_rom_pkg.sv
// Shared types and constants for the multi-port boot-ROM read controller.
// The optional ROM lock is built in only when SOC_ROM_LOCK_EN is defined.
package soc_rom_pkg;

  localparam int unsigned MAX_PORTS  = 8;
  localparam int unsigned MAX_DATA_W = 256;

  function automatic int unsigned port_id_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  localparam int unsigned PORT_ID_W = port_id_w(MAX_PORTS);

  localparam logic [MAX_DATA_W-1:0] ROM_ERR_DATA = '0;

  typedef struct packed {
    logic                 valid;
    logic [PORT_ID_W-1:0] port_id;
    logic                 err;
  } rom_pipe_entry_t;

endpackage

// File: rtl/soc_rom_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer moves past the winner.
module soc_rom_rr_arb
  import soc_rom_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 2,
  localparam int unsigned ID_W      = port_id_w(NUM_PORTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_gnt_c,
  output logic [ID_W-1:0]      o_win_c
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  logic            w_found;
  int unsigned     w_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_ptr <= '0;
    else          r_ptr <= w_ptr_nxt;
  end

  // Visit ports in order ptr, ptr+1, ... and take the first requester.
  always_comb begin
    o_gnt_c   = '0;
    o_win_c   = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_idx = 32'(r_ptr) + i;
      if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (!w_found && i_req[p] && (p == w_idx)) begin
          w_found    = 1'b1;
          o_gnt_c[p] = 1'b1;
          o_win_c    = ID_W'(p);
          w_ptr_nxt  = (p + 1 == NUM_PORTS) ? '0 : ID_W'(p + 1);
        end
      end
    end
  end

endmodule

// File: rtl/soc_rom_mp_ctrl.sv
// Multi-port pipelined boot-ROM read controller with round-robin arbitration.
// Optional sticky ROM lock enabled by defining SOC_ROM_LOCK_EN.
module soc_rom_mp_ctrl
  import soc_rom_pkg::*;
#(
  parameter  int unsigned NUM_PORTS      = 2,
  parameter  int unsigned ROM_ADDR_WIDTH = 13,
  parameter  int unsigned DATA_WIDTH     = 40,
  parameter  int unsigned READ_LAT       = 2,
  parameter  logic [31:0] BASE_ADDR      = 32'h1A00_0000,
  localparam int unsigned ID_W           = port_id_w(NUM_PORTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS*32-1:0]         add_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            r_valid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] r_rdata_o,
  output logic [NUM_PORTS-1:0]            r_err_o,
  output logic                            rom_cen_o,
  output logic [ROM_ADDR_WIDTH-3:0]       rom_a_o,
  input  logic [DATA_WIDTH-1:0]           rom_q_i,
  input  logic                            lock_i
);

  logic [NUM_PORTS-1:0]  w_req;
  logic [NUM_PORTS-1:0]  w_gnt;
  logic [ID_W-1:0]       w_win;
  logic                  w_any;
  logic [31:0]           w_add;
  logic [31:0]           w_off;
  logic                  w_in_range;
  logic                  w_locked;
  logic                  w_err;
  logic                  w_unused_off;
  logic [DATA_WIDTH-1:0] w_q;
  rom_pipe_entry_t       r_pipe [READ_LAT];
  rom_pipe_entry_t       w_last;

  // No grant can be issued while reset is asserted.
  assign w_req = req_i & {NUM_PORTS{rst_ni}};

  soc_rom_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_req   (w_req),
    .o_gnt_c (w_gnt),
    .o_win_c (w_win)
  );

  assign gnt_o = w_gnt;
  assign w_any = |w_gnt;

  always_comb begin
    w_add = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_gnt[p]) w_add = add_i[32*p +: 32];
    end
  end

  assign w_off        = w_add - BASE_ADDR;
  assign w_in_range   = (w_off[31:ROM_ADDR_WIDTH] == '0);
  assign w_unused_off = ^w_off[1:0];

`ifdef SOC_ROM_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)     r_lock <= 1'b0;
    else if (lock_i) r_lock <= 1'b1;
  end

  assign w_locked = r_lock;
`else
  logic w_unused_lock;

  assign w_unused_lock = lock_i;
  assign w_locked      = 1'b0;
`endif

  assign w_err     = !w_in_range || w_locked;
  assign rom_cen_o = !(w_any && !w_err);
  assign rom_a_o   = w_off[ROM_ADDR_WIDTH-1:2];

  // Response tags shift alongside the data so they emerge READ_LAT cycles after grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < READ_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= '{valid: w_any, port_id: PORT_ID_W'(w_win), err: w_err};
      for (int unsigned k = 1; k < READ_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  if (READ_LAT > 1) begin : g_dpipe
    logic [DATA_WIDTH-1:0] r_data [READ_LAT-1];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int unsigned k = 0; k < READ_LAT - 1; k++) r_data[k] <= '0;
      end else begin
        r_data[0] <= rom_q_i;
        for (int unsigned k = 1; k < READ_LAT - 1; k++) r_data[k] <= r_data[k-1];
      end
    end

    assign w_q = r_data[READ_LAT-2];
  end else begin : g_nodpipe
    assign w_q = rom_q_i;
  end

  assign w_last = r_pipe[READ_LAT-1];

  // Steer the head-of-pipe response to its port; everything else reads as zero.
  always_comb begin
    r_valid_o = '0;
    r_err_o   = '0;
    r_rdata_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (rst_ni && w_last.valid && (w_last.port_id == PORT_ID_W'(p))) begin
        r_valid_o[p] = 1'b1;
        r_err_o[p]   = w_last.err;
        r_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] =
          w_last.err ? DATA_WIDTH'(ROM_ERR_DATA) : w_q;
      end
    end
  end

endmodule

// File: tb/tb_soc_rom_mp_ctrl.sv
// Bench for soc_rom_mp_ctrl: directed table plus random traffic against a cycle-history model.
// Three instances: 2 ports/latency 2, 3 ports/latency 1, 3 ports/latency 4.
module tb_soc_rom_mp_ctrl;

  localparam logic [31:0] BASE = 32'h1A00_0000;
`ifdef SOC_ROM_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif
  localparam int NP  [3] = '{2, 3, 3};
  localparam int LAT [3] = '{2, 1, 4};

  logic        clk;
  logic        rst_n;
  logic        lock;
  logic [2:0]  req;
  logic [31:0] addr [3];

  logic [1:0]   g0, v0, e0;
  logic [79:0]  d0;
  logic         cen0;
  logic [10:0]  a0;
  logic [39:0]  q0;
  logic [2:0]   g1, v1, e1, g2, v2, e2;
  logic [119:0] d1, d2;
  logic         cen1, cen2;
  logic [10:0]  a1, a2;
  logic [39:0]  q1, q2;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc;
  int last_rst;
  int ptr_m [3];
  bit lock_m [3];
  bit          hv [3][8];
  int          hp [3][8];
  bit          he [3][8];
  logic [10:0] hw [3][8];

  typedef struct {
    logic        rst_n;
    logic [2:0]  req;
    logic [31:0] pa0;
    logic [31:0] pa1;
    logic        lock;
    logic [1:0]  exp_gnt;
    logic        exp_cen;
    logic [10:0] exp_a;
  } vec_t;

  vec_t vecs [$];

  soc_rom_mp_ctrl #(.NUM_PORTS(2), .READ_LAT(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1:0]), .add_i({addr[1], addr[0]}),
    .gnt_o(g0), .r_valid_o(v0), .r_rdata_o(d0), .r_err_o(e0),
    .rom_cen_o(cen0), .rom_a_o(a0), .rom_q_i(q0), .lock_i(lock));

  soc_rom_mp_ctrl #(.NUM_PORTS(3), .READ_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i({addr[2], addr[1], addr[0]}),
    .gnt_o(g1), .r_valid_o(v1), .r_rdata_o(d1), .r_err_o(e1),
    .rom_cen_o(cen1), .rom_a_o(a1), .rom_q_i(q1), .lock_i(lock));

  soc_rom_mp_ctrl #(.NUM_PORTS(3), .READ_LAT(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i({addr[2], addr[1], addr[0]}),
    .gnt_o(g2), .r_valid_o(v2), .r_rdata_o(d2), .r_err_o(e2),
    .rom_cen_o(cen2), .rom_a_o(a2), .rom_q_i(q2), .lock_i(lock));

  function automatic logic [39:0] rom_f(input logic [10:0] w);
    return {w[7:0] ^ 8'hC3, 32'(w) * 32'h9E37_79B1 + 32'h1234_5678};
  endfunction

  // ROM macros: data appears one cycle after an enabled access, otherwise holds.
  initial begin
    clk = 1'b0;
    q0  = '0;
    q1  = '0;
    q2  = '0;
  end
  always #5 clk = ~clk;
  always @(posedge clk) if (!cen0) q0 <= rom_f(a0);
  always @(posedge clk) if (!cen1) q1 <= rom_f(a1);
  always @(posedge clk) if (!cen2) q2 <= rom_f(a2);

  task automatic chk(input string nm, input int d, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s dut%0d cycle %0d: actual %h required %h", nm, d, cyc, act, exp);
    end
  endtask

  // Model: grant order from the spec's search rule; a response is due LAT cycles after
  // its grant unless a reset was seen at any point after the grant.
  task automatic check_cycle();
    if (!rst_n) last_rst = cyc;
    for (int d = 0; d < 3; d++) begin
      int          n = NP[d];
      int          l = LAT[d];
      int          win = -1;
      int          g;
      logic [127:0] eg, ev, ee, ed;
      logic        eerr = 1'b0;
      logic [10:0] eword = '0;
      logic [31:0] off;
      logic [127:0] ag, av, ae, ad;
      logic        acen;
      logic [10:0] aa;

      if (rst_n) begin
        for (int i = 0; i < n; i++) begin
          int p = (ptr_m[d] + i) % n;
          if (win < 0 && req[p]) win = p;
        end
      end
      eg = '0;
      if (win >= 0) begin
        eg[win] = 1'b1;
        off     = addr[win] - BASE;
        eerr    = (off >= 32'h2000) || lock_m[d];
        eword   = off[12:2];
      end

      case (d)
        0: begin ag = 128'(g0); av = 128'(v0); ae = 128'(e0); ad = 128'(d0); acen = cen0; aa = a0; end
        1: begin ag = 128'(g1); av = 128'(v1); ae = 128'(e1); ad = 128'(d1); acen = cen1; aa = a1; end
        default: begin ag = 128'(g2); av = 128'(v2); ae = 128'(e2); ad = 128'(d2); acen = cen2; aa = a2; end
      endcase

      chk("gnt", d, ag, eg);
      chk("rom_cen", d, 128'(acen), 128'(!(win >= 0 && !eerr)));
      if (win >= 0 && !eerr) chk("rom_a", d, 128'(aa), 128'(eword));

      ev = '0; ee = '0; ed = '0;
      g  = cyc - l;
      if (g >= 0 && hv[d][g % 8] && last_rst < g) begin
        ev[hp[d][g % 8]] = 1'b1;
        ee[hp[d][g % 8]] = he[d][g % 8];
        if (!he[d][g % 8]) ed[hp[d][g % 8]*40 +: 40] = rom_f(hw[d][g % 8]);
      end
      chk("r_valid", d, av, ev);
      chk("r_err", d, ae, ee);
      chk("r_rdata", d, ad, ed);

      hv[d][cyc % 8] = (win >= 0);
      hp[d][cyc % 8] = (win >= 0) ? win : 0;
      he[d][cyc % 8] = eerr;
      hw[d][cyc % 8] = eword;
      if (win >= 0) ptr_m[d] = (win + 1) % n;
      if (!rst_n) begin
        ptr_m[d]  = 0;
        lock_m[d] = 1'b0;
      end else if (lock && LOCK_ON) begin
        lock_m[d] = 1'b1;
      end
    end
  endtask

  function automatic void add_vec(input logic r, input logic [2:0] rq, input logic [31:0] x0,
                                  input logic [31:0] x1, input logic lk, input logic [1:0] eg,
                                  input logic ec, input logic [10:0] ea);
    vecs.push_back('{r, rq, x0, x1, lk, eg, ec, ea});
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return BASE + 32'($urandom_range(0, 32'h1FFF));
      2:       return BASE + 32'h2000 + 32'($urandom_range(0, 32'hFFFF));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst_n    = 1'b0;
    lock     = 1'b0;
    req      = '0;
    addr[0]  = '0;
    addr[1]  = '0;
    addr[2]  = '0;
    cyc      = -1;
    last_rst = -1;
    for (int d = 0; d < 3; d++) begin
      ptr_m[d]  = 0;
      lock_m[d] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        hv[d][k] = 1'b0; hp[d][k] = 0; he[d][k] = 1'b0; hw[d][k] = '0;
      end
    end

    //      rst  req   port0 addr     port1 addr     lock gnt   cen   rom_a
    add_vec(0, 3'b000, 32'h0,         32'h0,         0, 2'b00, 1'b1, 11'h0);
    add_vec(0, 3'b001, 32'h1A00_0010, 32'h0,         0, 2'b00, 1'b1, 11'h0);
    add_vec(1, 3'b001, 32'h1A00_0010, 32'h0,         0, 2'b01, 1'b0, 11'h004);
    add_vec(1, 3'b010, 32'h0,         32'h1A00_2000, 0, 2'b10, 1'b1, 11'h0);
    add_vec(1, 3'b000, 32'h0,         32'h0,         0, 2'b00, 1'b1, 11'h0);
    for (int i = 0; i < 6; i++)
      add_vec(1, 3'b011, 32'h1A00_0100, 32'h1A00_0204, 0, (i % 2 == 0) ? 2'b01 : 2'b10,
              1'b0, (i % 2 == 0) ? 11'h040 : 11'h081);
    add_vec(1, 3'b000, 32'h0,         32'h0,         0, 2'b00, 1'b1, 11'h0);
    add_vec(1, 3'b000, 32'h0,         32'h0,         0, 2'b00, 1'b1, 11'h0);
    add_vec(1, 3'b001, 32'h1A00_1FFC, 32'h0,         0, 2'b01, 1'b0, 11'h7FF);
    add_vec(1, 3'b011, 32'h19FF_FFFC, 32'h1A00_0000, 0, 2'b10, 1'b0, 11'h000);
    add_vec(1, 3'b001, 32'h19FF_FFFC, 32'h0,         0, 2'b01, 1'b1, 11'h0);
    add_vec(0, 3'b000, 32'h0,         32'h0,         0, 2'b00, 1'b1, 11'h0);
    add_vec(1, 3'b011, 32'h1A00_0008, 32'h1A00_000C, 0, 2'b01, 1'b0, 11'h002);
    for (int i = 0; i < 3; i++)
      add_vec(1, 3'b000, 32'h0, 32'h0, 0, 2'b00, 1'b1, 11'h0);
    // Lock pulse: the same-cycle read is normal, later grants error out only when locking is built in.
    add_vec(1, 3'b001, 32'h1A00_0000, 32'h0,         1, 2'b01, 1'b0, 11'h000);
    add_vec(1, 3'b001, 32'h1A00_0000, 32'h0,         0, 2'b01, LOCK_ON, 11'h000);
    add_vec(1, 3'b010, 32'h0,         32'h1A00_0040, 0, 2'b10, LOCK_ON, 11'h010);
    add_vec(1, 3'b000, 32'h0,         32'h0,         0, 2'b00, 1'b1, 11'h0);
    add_vec(1, 3'b000, 32'h0,         32'h0,         0, 2'b00, 1'b1, 11'h0);
    add_vec(0, 3'b000, 32'h0,         32'h0,         0, 2'b00, 1'b1, 11'h0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n   = vecs[i].rst_n;
      req     = vecs[i].req;
      addr[0] = vecs[i].pa0;
      addr[1] = vecs[i].pa1;
      addr[2] = 32'h0;
      lock    = vecs[i].lock;
      cyc++;
      @(negedge clk);
      check_cycle();
      chk("tbl_gnt", 0, 128'(g0), 128'(vecs[i].exp_gnt));
      chk("tbl_cen", 0, 128'(cen0), 128'(vecs[i].exp_cen));
      if (!vecs[i].exp_cen) chk("tbl_rom_a", 0, 128'(a0), 128'(vecs[i].exp_a));
    end

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      rst_n   = ($urandom_range(0, 199) != 0);
      req     = 3'($urandom_range(0, 7));
      addr[0] = rand_addr();
      addr[1] = rand_addr();
      addr[2] = rand_addr();
      lock    = ($urandom_range(0, 99) == 0);
      cyc++;
      @(negedge clk);
      check_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
